// File: rtl/seq_mult_signed_param_if.sv
// seq_mult_signed_param_if: start/busy/data_valid handshake bundle for the sequential signed multiplier
interface seq_mult_signed_param_if #(
    parameter int N = 8,
    parameter int M = 9,
    parameter int OUT_W = N + M
);
    logic                    start;
    logic signed [N-1:0]     in_a;
    logic signed [M-1:0]     in_b;
    logic                    busy;
    logic                    data_valid;
    logic signed [OUT_W-1:0] out;
    logic                    ovf;
    modport master (output start, in_a, in_b, input busy, data_valid, out, ovf);
    modport slave (input start, in_a, in_b, output busy, data_valid, out, ovf);
endinterface

// File: rtl/seq_mult_signed_param.sv
// seq_mult_signed_param: shift-add signed multiplier, one bit of in_a per clock, with rescale, rounding and saturation
module seq_mult_signed_param #(
    parameter int N = 8,
    parameter int M = 9,
    parameter int FRAC = 0,
    parameter int ROUND = 0,
    parameter int OUT_W = N + M
) (
    input logic clk,
    input logic rst_n,
    seq_mult_signed_param_if.slave bus
);
    localparam int W = N + M;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam int XW = (W + 1 > OUT_W ? W + 1 : OUT_W) + 1;
    localparam int RS = FRAC > 0 ? FRAC - 1 : 0;
    localparam logic signed [W:0] RND = (ROUND != 0 && FRAC > 0) ? (W + 1)'(1) << RS : '0;
    localparam logic signed [XW-1:0] OMAX = (XW'(1) << (OUT_W - 1)) - XW'(1);
    localparam logic signed [XW-1:0] OMIN = -(XW'(1) << (OUT_W - 1));
    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
    state_t state;
    logic [N-1:0] a;
    logic signed [W-1:0] b, acc, term, acc_nxt;
    logic [CW-1:0] count;
    logic last;
    logic signed [W:0] sum, r;
    logic signed [XW-1:0] rx;
    logic signed [OUT_W-1:0] sat_out;
    logic sat_ovf;
    // The sign bit of a carries weight -2^(N-1), so the last step subtracts.
    always_comb begin
        last = count == CW'(N - 1);
        term = a[count] ? b <<< count : '0;
        acc_nxt = last ? acc - term : acc + term;
        sum = {acc[W-1], acc} + RND;
        r = sum >>> FRAC;
        rx = {{(XW - W - 1){r[W]}}, r};
        sat_ovf = (rx > OMAX) || (rx < OMIN);
        sat_out = rx > OMAX ? OMAX[OUT_W-1:0] : rx < OMIN ? OMIN[OUT_W-1:0] : rx[OUT_W-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.out <= '0;
            bus.ovf <= 1'b0;
            count <= '0;
            acc <= '0;
            a <= '0;
            b <= '0;
        end else begin
            bus.data_valid <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    a <= bus.in_a;
                    b <= {{N{bus.in_b[M-1]}}, bus.in_b};
                    acc <= '0;
                    count <= '0;
                    bus.busy <= 1'b1;
                    state <= MUL;
                end
                MUL: begin
                    acc <= acc_nxt;
                    count <= last ? '0 : count + 1'b1;
                    state <= last ? FIN : MUL;
                end
                FIN: begin
                    bus.out <= sat_out;
                    bus.ovf <= sat_ovf;
                    bus.data_valid <= 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_signed_param.sv
// tb_seq_mult_signed_param: directed vector table plus handshake corner sequences for three parameterisations
module tb_seq_mult_signed_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_mult_signed_param_if #(.N(8), .M(9), .OUT_W(17)) if0 ();
    seq_mult_signed_param_if #(.N(8), .M(9), .OUT_W(9)) if1 ();
    seq_mult_signed_param_if #(.N(8), .M(9), .OUT_W(9)) if2 ();
    seq_mult_signed_param #(.N(8), .M(9), .FRAC(0), .ROUND(0), .OUT_W(17)) d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    seq_mult_signed_param #(.N(8), .M(9), .FRAC(7), .ROUND(1), .OUT_W(9)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq_mult_signed_param #(.N(8), .M(9), .FRAC(7), .ROUND(0), .OUT_W(9)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [2:0] st;
    logic signed [7:0] ia;
    logic signed [8:0] ib;
    logic signed [16:0] res [3];
    logic bsy [3];
    logic vld [3];
    logic ov [3];
    assign if0.start = st[0];
    assign if1.start = st[1];
    assign if2.start = st[2];
    assign if0.in_a = ia;
    assign if1.in_a = ia;
    assign if2.in_a = ia;
    assign if0.in_b = ib;
    assign if1.in_b = ib;
    assign if2.in_b = ib;
    assign res[0] = if0.out;
    assign res[1] = 17'(if1.out);
    assign res[2] = 17'(if2.out);
    assign bsy[0] = if0.busy;
    assign bsy[1] = if1.busy;
    assign bsy[2] = if2.busy;
    assign vld[0] = if0.data_valid;
    assign vld[1] = if1.data_valid;
    assign vld[2] = if2.data_valid;
    assign ov[0] = if0.ovf;
    assign ov[1] = if1.ovf;
    assign ov[2] = if2.ovf;

    typedef struct {
        int sel;
        int a;
        int b;
        int out;
        int ovf;
    } vec_t;
    vec_t tbl[$];
    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_op(input int sel, input int a, input int b, output longint o, output longint v,
                          output int lat, output int nb);
        @(negedge clk);
        ia = 8'(a);
        ib = 9'(b);
        st[sel] = 1'b1;
        @(posedge clk);
        #1;
        st[sel] = 1'b0;
        nb = int'(bsy[sel]);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            nb += int'(bsy[sel]);
            if (vld[sel]) break;
        end
        o = res[sel];
        v = longint'(ov[sel]);
    endtask

    function automatic longint prod(input int k);
        logic signed [7:0] x;
        logic signed [8:0] y;
        x = 8'(k * 7 - 50);
        y = 9'(k * 13 - 200);
        return longint'(x) * longint'(y);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint o, v;
        int lat, nb, nv;
        st = '0;
        ia = '0;
        ib = '0;
        tbl.push_back(vec_t'{0, 3, 5, 15, 0});
        tbl.push_back(vec_t'{0, -128, -256, 32768, 0});
        tbl.push_back(vec_t'{0, -1, 255, -255, 0});
        tbl.push_back(vec_t'{0, 0, -256, 0, 0});
        tbl.push_back(vec_t'{0, 127, 255, 32385, 0});
        tbl.push_back(vec_t'{0, -128, 255, -32640, 0});
        tbl.push_back(vec_t'{0, 127, -256, -32512, 0});
        tbl.push_back(vec_t'{0, 1, -1, -1, 0});
        tbl.push_back(vec_t'{1, 127, 255, 253, 0});
        tbl.push_back(vec_t'{1, -128, 255, -255, 0});
        tbl.push_back(vec_t'{1, 127, -256, -254, 0});
        tbl.push_back(vec_t'{1, 3, 5, 0, 0});
        tbl.push_back(vec_t'{1, -1, 1, 0, 0});
        tbl.push_back(vec_t'{2, 127, 255, 253, 0});
        tbl.push_back(vec_t'{2, -128, 255, -255, 0});
        tbl.push_back(vec_t'{2, 127, -256, -254, 0});
        tbl.push_back(vec_t'{2, -1, 1, -1, 0});
        tbl.push_back(vec_t'{2, -128, -256, 255, 1});
        tbl.push_back(vec_t'{1, -128, -256, 255, 1});

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", longint'(bsy[0]), 0);
        chk("reset data_valid", longint'(vld[0]), 0);
        chk("reset out", res[0], 0);
        chk("reset ovf", longint'(ov[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(tbl[i].sel, tbl[i].a, tbl[i].b, o, v, lat, nb);
            chk($sformatf("vec%0d out", i), o, tbl[i].out);
            chk($sformatf("vec%0d ovf", i), v, tbl[i].ovf);
            chk($sformatf("vec%0d latency", i), lat, 9);
            chk($sformatf("vec%0d busy cycles", i), nb, 9);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d pulse width", i), longint'(vld[tbl[i].sel]), 0);
        end

        run_op(0, 3, 5, o, v, lat, nb);
        repeat (5) @(posedge clk);
        #1;
        chk("hold out", res[0], 15);
        chk("hold ovf", longint'(ov[0]), 0);

        // operand changes and start pulses during busy must not disturb the running op
        @(negedge clk);
        ia = 8'sd3;
        ib = 9'sd5;
        st[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            ia = 8'(k * 17 - 60);
            ib = 9'(k * 29 + 100);
            st[0] = (k % 2) == 0;
        end
        st[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("busy-ignore valid", longint'(vld[0]), 1);
        chk("busy-ignore out", res[0], 15);
        nv = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            nv += int'(vld[0]);
        end
        chk("busy-ignore no queued op", nv, 0);

        // start held high, operands changing each cycle: accepts at cycles 0,10,20,30
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ia = 8'(c * 7 - 50);
            ib = 9'(c * 13 - 200);
            st[0] = 1'b1;
            @(posedge clk);
            #1;
            if (c % 10 == 9) begin
                chk($sformatf("stream c%0d valid", c), longint'(vld[0]), 1);
                chk($sformatf("stream c%0d out", c), res[0], prod(c - 9));
            end else begin
                nv += int'(vld[0]);
            end
        end
        @(negedge clk);
        st[0] = 1'b0;
        chk("stream stray valid", nv, 0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        ia = 8'sd3;
        ib = 9'sd5;
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", longint'(bsy[0]), 0);
        chk("abort data_valid", longint'(vld[0]), 0);
        chk("abort out", res[0], 0);
        chk("abort ovf", longint'(ov[0]), 0);
        chk("abort d1 ovf", longint'(ov[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            nv += int'(vld[0]);
        end
        chk("abort no pulse", nv, 0);
        run_op(0, 3, 5, o, v, lat, nb);
        chk("after abort out", o, 15);
        chk("after abort latency", lat, 9);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
